spi_frame_loader: RTL and testbench
===================================

Name: spi_frame_loader

Overview:
- Sits directly downstream of the SPI peripheral inside bnn_controller.
- Consumes its received byte stream (rx_data/rx_valid) and decodes a simple command framing.
- Assembles one binarised IMG_W x IMG_H image into a flat bit vector and presents it to the BNN core with a valid/ack handshake.
- Drives a registered status byte back toward the SPI transmit path.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- CMD_START, 8'hA0, command byte that opens a frame load
- CMD_CLEAR, 8'hC0, command byte that clears the image buffer and sticky error flags
- TIMEOUT_CYCLES, 1000000, max clk cycles allowed between data bytes during LOAD
- Derived, not overridable: IMG_BITS = IMG_W*IMG_H; NBYTES = ceil(IMG_BITS/8)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  byte received from SPI peripheral
- rx_valid  in  1  single-cycle strobe, rx_data valid
- frame_ack  in  1  BNN core has consumed the current image
- img_bits  out  IMG_BITS  assembled image; pixel 0 at MSB
- img_valid  out  1  image complete and stable
- tx_status  out  8  status byte for the SPI transmit register
- overrun_err  out  1  sticky: byte received while in READY
- timeout_err  out  1  sticky: inter-byte timeout during LOAD

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - state=IDLE, img_bits=0, img_valid=0
  - byte counter=0, timeout counter=0
  - overrun_err=0, timeout_err=0
  - tx_status=8'h05
- FSM states: IDLE, LOAD, READY.
- IDLE:
  - rx_valid with rx_data==CMD_START -> LOAD next cycle; byte counter=0, timeout counter=0, img_bits cleared to 0.
  - rx_valid with rx_data==CMD_CLEAR -> img_bits=0, overrun_err=0, timeout_err=0; stay IDLE.
  - Any other byte is ignored.
- LOAD:
  - Every rx_valid byte is data; no command decode.
  - Byte k (0-based) writes img_bits[IMG_BITS-1-8k-j] = rx_data[7-j] for j=0..7.
  - Bits that would fall below index 0 in the last byte when IMG_BITS%8!=0 are discarded.
  - Byte counter increments on each accepted byte.
  - On acceptance of byte NBYTES-1 -> READY; img_valid=1 from the next cycle. Latency from final rx_valid to img_valid is exactly 1 cycle.
  - Timeout counter resets on each rx_valid and otherwise increments.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without a byte -> IDLE; timeout_err=1; img_bits left partially written; img_valid stays 0.
- READY:
  - img_valid held at 1; img_bits frozen.
  - frame_ack=1 -> IDLE next cycle; img_valid=0 that same next cycle.
  - rx_valid in READY: byte dropped; overrun_err=1. This applies even to CMD_START and CMD_CLEAR.
  - Simultaneous frame_ack and rx_valid: go to IDLE, byte dropped, overrun_err=1.
  - frame_ack in IDLE or LOAD is ignored.
- tx_status, registered and updated every cycle:
  - bit7 = img_valid
  - bit6 = (state==LOAD)
  - bit5 = overrun_err
  - bit4 = timeout_err
  - bits3:0 = 4'h5
- Sticky errors clear only via reset or CMD_CLEAR in IDLE.
- Reset asserted mid-LOAD or mid-READY returns every register to its reset value on that clock edge. No partial frame survives reset.
- rx_valid is assumed to be a one-cycle pulse. A strobe held high N cycles counts as N bytes. No internal edge detection.
- Counter widths: byte counter $clog2(NBYTES+1) bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits; neither may wrap.

Test Plan:
- Reset, then idle 10 cycles -> img_valid=0, img_bits=0, tx_status=8'h05, both errors 0.
- Send A0 then 98 bytes: byte0=8'h80, bytes1..96=8'h00, byte97=8'h01 -> img_valid=1 exactly 1 cycle after the 98th rx_valid; img_bits[783]=1, img_bits[0]=1, all other bits 0; tx_status=8'h85.
- In READY, pulse frame_ack -> img_valid=0 next cycle, state IDLE, tx_status=8'h05. Pulse rx_valid with 8'h55 in the same cycle as frame_ack -> overrun_err=1, tx_status=8'h25.
- Send A0, 10 data bytes, then idle TIMEOUT_CYCLES (bench uses TIMEOUT_CYCLES=50) -> back to IDLE, timeout_err=1, tx_status=8'h15. Then send C0 -> errors cleared, img_bits=0, tx_status=8'h05.
- Send A0, 50 bytes of 8'hFF, assert rst for 1 cycle, then send A0 + 98 bytes of 8'h00 -> img_valid=1 with img_bits all zero; only 98 post-reset bytes counted.
- In IDLE, send 8'h12 then C0 then A0 + 98 x 8'hAA -> 8'h12 ignored; img_bits equals repeating 1010 pattern from MSB; img_valid=1.

Source files
------------

// File: rtl/spi_frame_loader.sv
// Decodes the SPI receive byte stream into one binarised image frame and hands it
// to the BNN core with a valid/ack handshake; also drives a registered status byte.
module spi_frame_loader #(
  parameter int          IMG_W          = 28,
  parameter int          IMG_H          = 28,
  parameter logic [7:0]  CMD_START      = 8'hA0,
  parameter logic [7:0]  CMD_CLEAR      = 8'hC0,
  parameter int          TIMEOUT_CYCLES = 1000000,
  localparam int         IMG_BITS       = IMG_W * IMG_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                frame_ack,
  output logic [IMG_BITS-1:0] img_bits,
  output logic                img_valid,
  output logic [7:0]          tx_status,
  output logic                overrun_err,
  output logic                timeout_err
);

  localparam int NBYTES   = (IMG_BITS + 7) / 8;
  localparam int PAD_BITS = NBYTES * 8;
  localparam int BW       = $clog2(NBYTES + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_e;

  state_e                state_q, state_d;
  logic [PAD_BITS-1:0]   img_q, img_d;
  logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  ovr_q, ovr_d;
  logic                  tmo_q, tmo_d;
  logic                  img_valid_q, img_valid_d;
  logic [7:0]            tx_status_q, tx_status_d;

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    img_d      = img_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    ovr_d      = ovr_q;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_START) begin
            state_d    = S_LOAD;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            img_d      = '0;
          end else if (rx_data == CMD_CLEAR) begin
            img_d = '0;
            ovr_d = 1'b0;
            tmo_d = 1'b0;
          end
        end
      end

      S_LOAD: begin
        if (rx_valid) begin
          // Byte k lands MSB-first at the top of the frame; pad bits below
          // index 0 of the image are never presented on img_bits.
          for (int k = 0; k < NBYTES; k++) begin
            if (byte_cnt_q == BW'(k)) img_d[PAD_BITS-1-8*k -: 8] = rx_data;
          end
          byte_cnt_d = byte_cnt_q + BW'(1);
          to_cnt_d   = '0;
          if (byte_cnt_q == BYTE_LAST) state_d = S_READY;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_READY: begin
        if (rx_valid)  ovr_d   = 1'b1;
        if (frame_ack) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Status mirrors the registers as they will be after this edge.
    img_valid_d = (state_d == S_READY);
    tx_status_d = {img_valid_d, state_d == S_LOAD, ovr_d, tmo_d, 4'h5};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      img_q       <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      ovr_q       <= 1'b0;
      tmo_q       <= 1'b0;
      img_valid_q <= 1'b0;
      tx_status_q <= 8'h05;
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      ovr_q       <= ovr_d;
      tmo_q       <= tmo_d;
      img_valid_q <= img_valid_d;
      tx_status_q <= tx_status_d;
    end
  end

  assign img_bits    = img_q[PAD_BITS-1 -: IMG_BITS];
  assign img_valid   = img_valid_q;
  assign tx_status   = tx_status_q;
  assign overrun_err = ovr_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: frame load, handshake, overrun,
// inter-byte timeout, mid-frame reset and command filtering.
module tb_spi_frame_loader;

  localparam int IMG_BITS   = 784;
  localparam int NBYTES     = 98;
  localparam int TB_TIMEOUT = 50;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic                frame_ack = 1'b0;
  logic [IMG_BITS-1:0] img_bits;
  logic                img_valid;
  logic [7:0]          tx_status;
  logic                overrun_err;
  logic                timeout_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  spi_frame_loader #(
    .IMG_W(28),
    .IMG_H(28),
    .CMD_START(8'hA0),
    .CMD_CLEAR(8'hC0),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_ack(frame_ack),
    .img_bits(img_bits),
    .img_valid(img_valid),
    .tx_status(tx_status),
    .overrun_err(overrun_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] b);
    send_byte(8'hA0);
    for (int i = 0; i < NBYTES; i++) send_byte(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    vec_cnt++;
    if (img_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_img_valid: got %b expected 0", img_valid); end
    vec_cnt++;
    if (img_bits !== '0) begin err_cnt++; $display("FAIL reset_img_bits: got %h expected 0", img_bits); end
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL reset_tx_status: got %h expected 05", tx_status); end
    vec_cnt++;
    if ({overrun_err, timeout_err} !== 2'b00) begin
      err_cnt++; $display("FAIL reset_errors: got %b expected 00", {overrun_err, timeout_err});
    end
  endtask

  task automatic test_frame_load();
    logic [IMG_BITS-1:0] exp_img;
    exp_img = '0;
    exp_img[IMG_BITS-1] = 1'b1;
    exp_img[0] = 1'b1;
    send_byte(8'hA0);
    vec_cnt++;
    if (tx_status !== 8'h45) begin err_cnt++; $display("FAIL load_tx_status: got %h expected 45", tx_status); end
    send_byte(8'h80);
    for (int i = 1; i < NBYTES - 1; i++) send_byte(8'h00);
    // Final byte: img_valid must still be low with the strobe up, high one edge later.
    @(negedge clk);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    vec_cnt++;
    if (img_valid !== 1'b0) begin err_cnt++; $display("FAIL early_img_valid: got %b expected 0", img_valid); end
    @(negedge clk);
    rx_valid = 1'b0;
    vec_cnt++;
    if (img_valid !== 1'b1) begin err_cnt++; $display("FAIL latency_img_valid: got %b expected 1", img_valid); end
    vec_cnt++;
    if (img_bits !== exp_img) begin err_cnt++; $display("FAIL frame_img_bits: got %h expected %h", img_bits, exp_img); end
    vec_cnt++;
    if (tx_status !== 8'h85) begin err_cnt++; $display("FAIL ready_tx_status: got %h expected 85", tx_status); end
  endtask

  task automatic test_ack_overrun();
    logic [IMG_BITS-1:0] exp_img;
    exp_img = {NBYTES{8'h3C}};
    pulse_ack();
    vec_cnt++;
    if (img_valid !== 1'b0) begin err_cnt++; $display("FAIL ack_img_valid: got %b expected 0", img_valid); end
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL ack_tx_status: got %h expected 05", tx_status); end

    // Ack and byte in the same cycle: leave READY, drop byte, flag overrun.
    load_frame(8'h3C);
    @(negedge clk);
    frame_ack = 1'b1;
    rx_data   = 8'h55;
    rx_valid  = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    vec_cnt++;
    if (overrun_err !== 1'b1) begin err_cnt++; $display("FAIL simul_overrun: got %b expected 1", overrun_err); end
    vec_cnt++;
    if (tx_status !== 8'h25) begin err_cnt++; $display("FAIL simul_tx_status: got %h expected 25", tx_status); end
    send_byte(8'hC0);
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL clear_overrun_tx: got %h expected 05", tx_status); end

    // Commands arriving in READY are dropped and flagged, image frozen.
    load_frame(8'h3C);
    send_byte(8'hA0);
    vec_cnt++;
    if (tx_status !== 8'hA5) begin err_cnt++; $display("FAIL ready_start_tx: got %h expected a5", tx_status); end
    send_byte(8'hC0);
    vec_cnt++;
    if (img_bits !== exp_img) begin err_cnt++; $display("FAIL ready_frozen_img: got %h expected %h", img_bits, exp_img); end
    vec_cnt++;
    if ({img_valid, overrun_err} !== 2'b11) begin
      err_cnt++; $display("FAIL ready_clear_ignored: got %b expected 11", {img_valid, overrun_err});
    end
    pulse_ack();
    vec_cnt++;
    if (tx_status !== 8'h25) begin err_cnt++; $display("FAIL ack2_tx_status: got %h expected 25", tx_status); end
    send_byte(8'hC0);
  endtask

  task automatic test_timeout();
    logic [IMG_BITS-1:0] exp_img;
    exp_img = '0;
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL pre_timeout_tx: got %h expected 05", tx_status); end
    send_byte(8'hA0);
    pulse_ack();
    vec_cnt++;
    if (tx_status !== 8'h45) begin err_cnt++; $display("FAIL load_ack_ignored: got %h expected 45", tx_status); end
    for (int k = 0; k < 10; k++) begin
      send_byte(8'(8'h11 * (k + 1)));
      exp_img[IMG_BITS-1-8*k -: 8] = 8'(8'h11 * (k + 1));
    end
    idle(TB_TIMEOUT - 1);
    vec_cnt++;
    if (tx_status !== 8'h45) begin err_cnt++; $display("FAIL timeout_early: got %h expected 45", tx_status); end
    idle(1);
    vec_cnt++;
    if (tx_status !== 8'h15) begin err_cnt++; $display("FAIL timeout_tx_status: got %h expected 15", tx_status); end
    vec_cnt++;
    if ({img_valid, timeout_err} !== 2'b01) begin
      err_cnt++; $display("FAIL timeout_flags: got %b expected 01", {img_valid, timeout_err});
    end
    vec_cnt++;
    if (img_bits !== exp_img) begin err_cnt++; $display("FAIL timeout_partial_img: got %h expected %h", img_bits, exp_img); end
    send_byte(8'hC0);
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL clear_tx_status: got %h expected 05", tx_status); end
    vec_cnt++;
    if (img_bits !== '0) begin err_cnt++; $display("FAIL clear_img_bits: got %h expected 0", img_bits); end
    vec_cnt++;
    if ({overrun_err, timeout_err} !== 2'b00) begin
      err_cnt++; $display("FAIL clear_errors: got %b expected 00", {overrun_err, timeout_err});
    end
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'hA0);
    for (int i = 0; i < 50; i++) send_byte(8'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL midrst_tx_status: got %h expected 05", tx_status); end
    vec_cnt++;
    if (img_bits !== '0) begin err_cnt++; $display("FAIL midrst_img_bits: got %h expected 0", img_bits); end
    send_byte(8'hA0);
    for (int i = 0; i < NBYTES - 1; i++) send_byte(8'h00);
    vec_cnt++;
    if (img_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_97_valid: got %b expected 0", img_valid); end
    send_byte(8'h00);
    vec_cnt++;
    if (img_valid !== 1'b1) begin err_cnt++; $display("FAIL midrst_98_valid: got %b expected 1", img_valid); end
    vec_cnt++;
    if (img_bits !== '0) begin err_cnt++; $display("FAIL midrst_frame_img: got %h expected 0", img_bits); end
    pulse_ack();
  endtask

  task automatic test_ignore_and_pattern();
    logic [IMG_BITS-1:0] exp_img;
    exp_img = {NBYTES{8'hAA}};
    send_byte(8'h12);
    vec_cnt++;
    if (tx_status !== 8'h05) begin err_cnt++; $display("FAIL junk_ignored: got %h expected 05", tx_status); end
    send_byte(8'hC0);
    load_frame(8'hAA);
    vec_cnt++;
    if (img_valid !== 1'b1) begin err_cnt++; $display("FAIL pattern_valid: got %b expected 1", img_valid); end
    vec_cnt++;
    if (img_bits !== exp_img) begin err_cnt++; $display("FAIL pattern_img: got %h expected %h", img_bits, exp_img); end
    vec_cnt++;
    if (tx_status !== 8'h85) begin err_cnt++; $display("FAIL pattern_tx_status: got %h expected 85", tx_status); end
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_frame_load();
    test_ack_overrun();
    test_timeout();
    test_reset_mid_load();
    test_ignore_and_pattern();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
